// File: rtl/fullxor_sched_if.sv
// Bundle of the requester, randomness, XOR-unit and result signals of fullxor_sched.
// The slave modport is the scheduler's view; master is the surrounding system.
interface fullxor_sched_if #(
  parameter int unsigned K_WIDTH  = 32,
  parameter int unsigned N_SHARES = 3,
  parameter int unsigned RANDNUM  = 2
);
  logic                          req0_vld;
  logic                          req0_rdy;
  logic [K_WIDTH*N_SHARES-1:0]   req0_x;
  logic                          req1_vld;
  logic                          req1_rdy;
  logic [K_WIDTH*N_SHARES-1:0]   req1_x;
  logic                          rnd_vld;
  logic                          rnd_rdy;
  logic [K_WIDTH*RANDNUM-1:0]    rnd_data;
  logic                          xor_dvld;
  logic                          xor_ena;
  logic [K_WIDTH*N_SHARES-1:0]   xor_x;
  logic [K_WIDTH*RANDNUM-1:0]    xor_rnd;
  logic [K_WIDTH-1:0]            xor_z;
  logic                          xor_ovld;
  logic                          out_vld;
  logic                          out_rdy;
  logic [K_WIDTH-1:0]            out_z;
  logic                          out_id;
  logic                          busy;
  logic                          err;
  logic                          rnd_starve;

  modport slave (
    input  req0_vld, req0_x, req1_vld, req1_x, rnd_vld, rnd_data, xor_z, xor_ovld, out_rdy,
    output req0_rdy, req1_rdy, rnd_rdy, xor_dvld, xor_ena, xor_x, xor_rnd,
    output out_vld, out_z, out_id, busy, err, rnd_starve
  );

  modport master (
    output req0_vld, req0_x, req1_vld, req1_x, rnd_vld, rnd_data, xor_z, xor_ovld, out_rdy,
    input  req0_rdy, req1_rdy, rnd_rdy, xor_dvld, xor_ena, xor_x, xor_rnd,
    input  out_vld, out_z, out_id, busy, err, rnd_starve
  );
endinterface

// File: rtl/fullxor_sched.sv
// Round-robin two-requester scheduler for a 3-share masked XOR unit with fresh randomness.
// Optional randomness-starvation watchdog enabled by defining FULLXOR_SCHED_WDOG_EN.
module fullxor_sched #(
  parameter int unsigned K_WIDTH  = 32,
  parameter int unsigned N_SHARES = 3,
  parameter int unsigned RANDNUM  = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input logic            clk,
  input logic            rst,
  fullxor_sched_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               r_state;
  logic                 r_rr;
  logic                 r_id;
  logic                 r_out_vld;
  logic [K_WIDTH-1:0]   r_out_z;
  logic                 r_out_id;
  logic                 r_err;

  logic w_any_req;
  logic w_issue;
  logic w_gnt;

  assign w_any_req = bus.req0_vld | bus.req1_vld;
  // Gated by rst so nothing is handed out while the block is held in reset.
  assign w_issue   = (r_state == StIdle) & w_any_req & bus.rnd_vld & ~rst;
  assign w_gnt     = (bus.req0_vld & bus.req1_vld) ? ~r_rr : bus.req1_vld;

  assign bus.req0_rdy = w_issue & ~w_gnt;
  assign bus.req1_rdy = w_issue & w_gnt;
  assign bus.rnd_rdy  = w_issue;
  assign bus.xor_dvld = w_issue;
  assign bus.xor_ena  = w_issue | (r_state == StBusy);
  assign bus.xor_x    = w_issue ? (w_gnt ? bus.req1_x : bus.req0_x) : '0;
  assign bus.xor_rnd  = w_issue ? bus.rnd_data : '0;

  assign bus.out_vld = r_out_vld;
  assign bus.out_z   = r_out_z;
  assign bus.out_id  = r_out_id;
  assign bus.busy    = (r_state != StIdle);
  assign bus.err     = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_rr      <= 1'b1;
      r_id      <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_z   <= '0;
      r_out_id  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_issue) begin
            r_rr    <= w_gnt;
            r_id    <= w_gnt;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          if (bus.xor_ovld) begin
            r_out_z   <= bus.xor_z;
            r_out_id  <= r_id;
            r_out_vld <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_err   <= 1'b1;
            r_state <= StIdle;
          end
        end
        StDone: begin
          if (bus.out_rdy) begin
            r_out_vld <= 1'b0;
            r_out_z   <= '0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef FULLXOR_SCHED_WDOG_EN
  localparam logic [7:0] LpTimeout = 8'(TIMEOUT);

  logic [7:0] r_wdog;
  logic [7:0] w_wdog_d;
  logic       r_starve;

  // Counts idle cycles where a request waits only on randomness; holds outside IDLE.
  always_comb begin
    w_wdog_d = r_wdog;
    if (w_issue || !w_any_req) begin
      w_wdog_d = '0;
    end else if ((r_state == StIdle) && !bus.rnd_vld && (r_wdog != LpTimeout)) begin
      w_wdog_d = r_wdog + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog   <= '0;
      r_starve <= 1'b0;
    end else begin
      r_wdog <= w_wdog_d;
      if (w_wdog_d == LpTimeout) r_starve <= 1'b1;
    end
  end

  assign bus.rnd_starve = r_starve;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign bus.rnd_starve   = 1'b0;
`endif
endmodule

// File: tb/tb_fullxor_sched.sv
// Randomized bench for fullxor_sched against a transaction-level scoreboard model.
// Includes an XOR-unit model with optional ovld suppression for error injection.
module tb_fullxor_sched;
  localparam int unsigned KW = 32;
  localparam int unsigned NS = 3;
  localparam int unsigned RN = 2;
  localparam int unsigned XW = KW * NS;
  localparam int unsigned RW = KW * RN;
`ifdef FULLXOR_SCHED_WDOG_EN
  localparam bit WdogEn = 1'b1;
`else
  localparam bit WdogEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   kill;
  int   n_vec = 0;
  int   n_err = 0;

  fullxor_sched_if #(.K_WIDTH(KW), .N_SHARES(NS), .RANDNUM(RN)) u_bus ();

  fullxor_sched #(.K_WIDTH(KW), .N_SHARES(NS), .RANDNUM(RN), .TIMEOUT(255)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [KW-1:0] unmask(input logic [XW-1:0] x);
    logic [KW-1:0] r = '0;
    for (int i = 0; i < NS; i++) r ^= x[i*KW +: KW];
    return r;
  endfunction

  // Recombination unit: registered result one cycle after dvld&ena, ovld suppressible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_bus.xor_ovld <= 1'b0;
      u_bus.xor_z    <= '0;
    end else begin
      u_bus.xor_ovld <= u_bus.xor_dvld & u_bus.xor_ena & ~kill;
      u_bus.xor_z    <= u_bus.xor_dvld ? unmask(u_bus.xor_x) : '0;
    end
  end

  // Scoreboard: at most one outstanding operation, tracked by its issue cycle.
  int            cyc = 0;
  bit            op_v, op_id, op_kill;
  logic [KW-1:0] op_z;
  int            op_t;
  bit            m_last = 1'b1;
  bit            m_err, m_starve;
  int            m_cnt;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [XW-1:0] rx();
    logic [XW-1:0] r;
    for (int i = 0; i < NS; i++) r[i*KW +: KW] = $urandom;
    return r;
  endfunction

  function automatic logic [RW-1:0] rr_data();
    logic [RW-1:0] r;
    for (int i = 0; i < RN; i++) r[i*KW +: KW] = $urandom;
    return r;
  endfunction

  task automatic step(input bit v0, input bit v1, input logic [XW-1:0] x0, input logic [XW-1:0] x1,
                      input bit rv, input logic [RW-1:0] rd, input bit ordy, input bit kl);
    bit            e_issue, e_g, e_ovld, idle;
    logic [XW-1:0] e_x;
    @(negedge clk);
    u_bus.req0_vld = v0;  u_bus.req0_x = x0;
    u_bus.req1_vld = v1;  u_bus.req1_x = x1;
    u_bus.rnd_vld  = rv;  u_bus.rnd_data = rd;
    u_bus.out_rdy  = ordy;
    kill = kl;
    #1;
    idle    = !op_v;
    e_issue = idle && (v0 || v1) && rv;
    e_g     = (v0 && v1) ? !m_last : v1;
    e_x     = e_issue ? (e_g ? x1 : x0) : '0;
    e_ovld  = op_v && !op_kill && (cyc >= op_t + 2);
    chk("req0_rdy", u_bus.req0_rdy, e_issue && !e_g);
    chk("req1_rdy", u_bus.req1_rdy, e_issue && e_g);
    chk("rnd_rdy", u_bus.rnd_rdy, e_issue);
    chk("xor_dvld", u_bus.xor_dvld, e_issue);
    chk("xor_ena", u_bus.xor_ena, e_issue || (op_v && cyc == op_t + 1));
    chk("xor_x", u_bus.xor_x, e_x);
    chk("xor_rnd", u_bus.xor_rnd, e_issue ? rd : '0);
    chk("out_vld", u_bus.out_vld, e_ovld);
    chk("out_z", u_bus.out_z, e_ovld ? op_z : '0);
    if (e_ovld) chk("out_id", u_bus.out_id, op_id);
    chk("busy", u_bus.busy, op_v);
    chk("err", u_bus.err, m_err);
    chk("rnd_starve", u_bus.rnd_starve, m_starve);
    if (op_v && op_kill && cyc == op_t + 1) begin
      op_v  = 1'b0;
      m_err = 1'b1;
    end else if (e_ovld && ordy) begin
      op_v = 1'b0;
    end
    if (e_issue) begin
      op_v    = 1'b1;
      op_id   = e_g;
      op_z    = unmask(e_x);
      op_t    = cyc;
      op_kill = kl;
      m_last  = e_g;
    end
    if (WdogEn) begin
      if (e_issue || !(v0 || v1)) m_cnt = 0;
      else if (idle && !rv && m_cnt < 255) m_cnt++;
      if (m_cnt == 255) m_starve = 1'b1;
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic clear_inputs();
    u_bus.req0_vld = 1'b0; u_bus.req0_x = '0;
    u_bus.req1_vld = 1'b0; u_bus.req1_x = '0;
    u_bus.rnd_vld  = 1'b0; u_bus.rnd_data = '0;
    u_bus.out_rdy  = 1'b0;
    kill = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_vld"}, u_bus.out_vld, 1'b0);
    chk({tag, "_out_z"}, u_bus.out_z, '0);
    chk({tag, "_out_id"}, u_bus.out_id, 1'b0);
    chk({tag, "_busy"}, u_bus.busy, 1'b0);
    chk({tag, "_err"}, u_bus.err, 1'b0);
    chk({tag, "_starve"}, u_bus.rnd_starve, 1'b0);
    chk({tag, "_req0_rdy"}, u_bus.req0_rdy, 1'b0);
    chk({tag, "_rnd_rdy"}, u_bus.rnd_rdy, 1'b0);
    chk({tag, "_xor_dvld"}, u_bus.xor_dvld, 1'b0);
  endtask

  task automatic model_reset();
    op_v = 1'b0; m_last = 1'b1; m_err = 1'b0; m_starve = 1'b0; m_cnt = 0;
  endtask

  logic [XW-1:0] xa;

  initial begin
    clear_inputs();
    model_reset();
    // Requests pending while in reset must not be granted.
    u_bus.req0_vld = 1'b1;
    u_bus.rnd_vld  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_checks("rst");
    clear_inputs();
    @(negedge clk) rst = 1'b0;

    // Single operation with known shares.
    xa = {32'h12345678, 32'h0F0F0F0F, 32'hA5A5A5A5};
    step(1'b1, 1'b0, xa, '0, 1'b1, rr_data(), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("single_z", u_bus.out_z, 32'hB89EFCD2);
    chk("single_id", u_bus.out_id, 1'b0);
    drain(2);

    // Fairness with both requesters held valid.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, rx(), rx(), 1'b1, rr_data(), 1'b1, 1'b0);
    drain(3);

    // Randomness stall.
    xa = rx();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, rx(), xa, 1'b0, rr_data(), 1'b1, 1'b0);
    step(1'b0, 1'b1, rx(), xa, 1'b1, rr_data(), 1'b1, 1'b0);
    drain(3);

    // Backpressure with both requesters waiting.
    step(1'b1, 1'b0, rx(), '0, 1'b1, rr_data(), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, rx(), rx(), 1'b1, rr_data(), 1'b0, 1'b0);
    step(1'b1, 1'b1, rx(), rx(), 1'b1, rr_data(), 1'b1, 1'b0);
    drain(3);

    // Missing ovld from the unit.
    step(1'b0, 1'b1, '0, rx(), 1'b1, rr_data(), 1'b1, 1'b1);
    drain(3);
    chk("err_sticky", u_bus.err, 1'b1);

    // Randomness starvation.
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0, rx(), '0, 1'b0, rr_data(), 1'b1, 1'b0);
    step(1'b1, 1'b0, rx(), '0, 1'b1, rr_data(), 1'b1, 1'b0);
    drain(4);
    chk("wdog_sticky", u_bus.rnd_starve, WdogEn);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, rx(), rx(), ($urandom % 4) != 0, rr_data(),
           ($urandom % 3) != 0, ($urandom % 16) == 0);
    end
    drain(4);

    // Asynchronous reset while a result is held.
    step(1'b0, 1'b1, '0, rx(), 1'b1, rr_data(), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    u_bus.req0_vld = 1'b1;
    u_bus.rnd_vld  = 1'b1;
    #2 rst = 1'b1;
    #1 reset_checks("async_rst");
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
    cyc += 4;

    // Pointer restarts with requester 0 first.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, rx(), rx(), 1'b1, rr_data(), 1'b1, 1'b0);
    drain(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
